symmetric_fir: RTL and testbench
================================

Name: symmetric_fir

Overview:
- 12-tap, even-symmetric, linear-phase FIR filter on a signed sample stream, one sample per clock.
- Six unique signed coefficients are loaded through a parallel load strobe; tap k and tap 11-k share coefficient k.
- Pre-adder, multiplier and adder stages are each registered, giving a fixed latency.
- Sits in the datapath between a signed sample source and downstream DSP logic.

Parameters:
- DATA_WIDTH, 12, width of the signed input sample.
- COEFF_WIDTH, 8, width of each signed coefficient.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- load_i  input  1  coefficient load strobe.
- coef0_i..coef5_i  input  COEFF_WIDTH each  signed coefficients c0..c5.
- signal_i  input  DATA_WIDTH  signed input sample, accepted every cycle.
- signal_o  output  DATA_WIDTH+COEFF_WIDTH+2 (22 by default)  signed filter output, registered.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset (rst_i=1 at a rising edge):
  - Clears coefficient registers, delay line, pre-add registers, product registers and signal_o to 0.
  - Reset has priority over load_i and over sample shifting.
  - Reset asserted mid-stream discards all history.
  - signal_o reads 0 from the edge after reset is sampled until new data propagates.
- Coefficient registers:
  - load_i=1 at an edge captures coef0_i..coef5_i.
  - Otherwise the registers hold their value; the coef inputs are ignored while load_i=0.
- Delay line, updated every non-reset edge:
  - d[0] <= signal_i.
  - d[k] <= d[k-1] for k=1..11.
  - The delay line is never stalled.
- Pre-add stage: p[k] <= d[k] + d[11-k], k=0..5, sign-extended to DATA_WIDTH+1 bits. No overflow is possible.
- Multiply stage: m[k] <= creg[k] * p[k], signed, DATA_WIDTH+COEFF_WIDTH+1 bits. Exact.
- Output stage: signal_o <= m[0]+...+m[5].
  - Computed signed, then truncated to DATA_WIDTH+COEFF_WIDTH+2 bits, wrapping modulo 2^22.
  - No saturation.
- Latency: a sample present on signal_i at edge n first affects signal_o after edge n+3 (through tap c0).
- Impulse response at signal_o, edges n+3..n+14: c0,c1,c2,c3,c4,c5,c5,c4,c3,c2,c1,c0.
- Coefficient change mid-stream:
  - A coefficient loaded at edge n is used by products computed at edge n+1 and reaches signal_o after edge n+2.
  - There is no pipeline flush, so outputs in transition mix old and new coefficients.
- Simultaneous load_i and data: both occur in the same cycle; sample flow is unaffected.
- Each coefficient register is updated only via load_i.

Test Plan:
- Reset: hold rst_i=1 for 4 cycles with random signal_i -> signal_o=0 throughout and on the first cycle after release.
- Impulse: load c=1,2,3,4,5,6; drive signal_i=1 for one cycle, then 0 -> signal_o after edges n+3..n+14 = 1,2,3,4,5,6,6,5,4,3,2,1, then 0.
- DC: load all c=1; drive signal_i=10 constantly -> signal_o settles to 120 (12 taps × 10) and stays constant.
- Wrap-around: load all c=-128; drive signal_i=-2048 constantly -> per-pair product +524288, true sum 3145728, signal_o settles to -1048576.
- Mid-stream reload: DC 10 with all c=1, then load all c=2 -> signal_o goes 120 then 240, with the change visible 2 edges after the load edge.
- Reset mid-operation: during a noisy sine (amplitude 500, period 12) with random coefficients, assert rst_i for one cycle -> signal_o=0 next cycle.
  - With coefficients now 0, signal_o remains 0 until a new load.

Source files
------------

// File: rtl/symmetric_fir.sv
// 12-tap even-symmetric linear-phase FIR: pre-add, multiply and sum stages are each
// registered, so a sample reaches signal_o three edges after it is taken in.
module symmetric_fir #(
    parameter int DATA_WIDTH  = 12,
    parameter int COEFF_WIDTH = 8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   load_i,
    input  logic signed [COEFF_WIDTH-1:0]          coef0_i,
    input  logic signed [COEFF_WIDTH-1:0]          coef1_i,
    input  logic signed [COEFF_WIDTH-1:0]          coef2_i,
    input  logic signed [COEFF_WIDTH-1:0]          coef3_i,
    input  logic signed [COEFF_WIDTH-1:0]          coef4_i,
    input  logic signed [COEFF_WIDTH-1:0]          coef5_i,
    input  logic signed [DATA_WIDTH-1:0]           signal_i,
    output logic signed [DATA_WIDTH+COEFF_WIDTH+1:0] signal_o
);

    localparam int NTAPS  = 12;
    localparam int NPAIRS = NTAPS / 2;
    localparam int PW     = DATA_WIDTH + 1;
    localparam int MW     = DATA_WIDTH + COEFF_WIDTH + 1;
    localparam int OW     = DATA_WIDTH + COEFF_WIDTH + 2;

    logic signed [COEFF_WIDTH-1:0] coef_q  [NPAIRS];
    logic signed [COEFF_WIDTH-1:0] coef_d  [NPAIRS];
    logic signed [DATA_WIDTH-1:0]  delay_q [NTAPS];
    logic signed [DATA_WIDTH-1:0]  delay_d [NTAPS];
    logic signed [PW-1:0]          pre_q   [NPAIRS];
    logic signed [PW-1:0]          pre_d   [NPAIRS];
    logic signed [MW-1:0]          prod_q  [NPAIRS];
    logic signed [MW-1:0]          prod_d  [NPAIRS];
    logic signed [OW-1:0]          sum_q;
    logic signed [OW-1:0]          sum_d;

    always_comb begin
        coef_d = coef_q;
        if (load_i) begin
            coef_d[0] = coef0_i;
            coef_d[1] = coef1_i;
            coef_d[2] = coef2_i;
            coef_d[3] = coef3_i;
            coef_d[4] = coef4_i;
            coef_d[5] = coef5_i;
        end

        delay_d[0] = signal_i;
        for (int k = 1; k < NTAPS; k++) begin
            delay_d[k] = delay_q[k-1];
        end

        // Symmetric taps share a coefficient, so fold each pair before multiplying.
        for (int k = 0; k < NPAIRS; k++) begin
            pre_d[k]  = PW'(delay_q[k]) + PW'(delay_q[NTAPS-1-k]);
            prod_d[k] = MW'(coef_q[k]) * MW'(pre_q[k]);
        end

        // Accumulating at the output width gives the modulo-2^OW wrap directly.
        sum_d = '0;
        for (int k = 0; k < NPAIRS; k++) begin
            sum_d = sum_d + OW'(prod_q[k]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            coef_q  <= '{default: '0};
            delay_q <= '{default: '0};
            pre_q   <= '{default: '0};
            prod_q  <= '{default: '0};
            sum_q   <= '0;
        end else begin
            coef_q  <= coef_d;
            delay_q <= delay_d;
            pre_q   <= pre_d;
            prod_q  <= prod_d;
            sum_q   <= sum_d;
        end
    end

    assign signal_o = sum_q;

endmodule

// File: tb/tb_symmetric_fir.sv
// Directed self-checking bench for symmetric_fir: reset, impulse, DC, wrap-around,
// mid-stream coefficient reload and mid-stream reset.
module tb_symmetric_fir;

    localparam int DW = 12;
    localparam int CW = 8;
    localparam int OW = DW + CW + 2;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 load_i = 1'b0;
    logic signed [CW-1:0] coef_drv [6];
    logic signed [DW-1:0] signal_i = '0;
    logic signed [OW-1:0] signal_o;

    int check_count = 0;
    int error_count = 0;

    int sine_tbl [12] = '{0, 250, 433, 500, 433, 250, 0, -250, -433, -500, -433, -250};

    symmetric_fir #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (load_i),
        .coef0_i  (coef_drv[0]),
        .coef1_i  (coef_drv[1]),
        .coef2_i  (coef_drv[2]),
        .coef3_i  (coef_drv[3]),
        .coef4_i  (coef_drv[4]),
        .coef5_i  (coef_drv[5]),
        .signal_i (signal_i),
        .signal_o (signal_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive one cycle of inputs, then return 1 time unit after the rising edge.
    task automatic applyStimulus(input logic rst, input logic ld, input logic signed [DW-1:0] sig);
        rst_i    = rst;
        load_i   = ld;
        signal_i = sig;
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic signed [OW-1:0] got,
                               input logic signed [OW-1:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic setCoefs(input int c0, input int c1, input int c2,
                            input int c3, input int c4, input int c5);
        coef_drv[0] = CW'(c0);
        coef_drv[1] = CW'(c1);
        coef_drv[2] = CW'(c2);
        coef_drv[3] = CW'(c3);
        coef_drv[4] = CW'(c4);
        coef_drv[5] = CW'(c5);
    endtask

    initial begin
        int imp_c [6];
        logic signed [OW-1:0] exp;

        setCoefs(0, 0, 0, 0, 0, 0);

        // Reset held for 4 cycles with random samples, then the first cycle after release.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, DW'($urandom));
            checkOutput("reset_hold", signal_o, '0);
        end
        applyStimulus(1'b0, 1'b0, DW'($urandom));
        checkOutput("reset_release", signal_o, '0);

        // Impulse with c = 1..6.
        applyStimulus(1'b1, 1'b0, '0);
        imp_c = '{1, 2, 3, 4, 5, 6};
        setCoefs(1, 2, 3, 4, 5, 6);
        applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 12'sd1);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 1'b0, '0);
            if (i >= 3 && i <= 14) begin
                exp = OW'(imp_c[(i - 3 < 6) ? (i - 3) : (14 - i)]);
            end else begin
                exp = '0;
            end
            checkOutput($sformatf("impulse_n+%0d", i), signal_o, exp);
        end

        // DC input 10 with all coefficients 1.
        applyStimulus(1'b1, 1'b0, '0);
        setCoefs(1, 1, 1, 1, 1, 1);
        applyStimulus(1'b0, 1'b1, 12'sd10);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 12'sd10);
            if (i >= 15) checkOutput("dc_settled", signal_o, 22'sd120);
        end

        // Reload all coefficients to 2 mid-stream; the change lands two edges later.
        setCoefs(2, 2, 2, 2, 2, 2);
        applyStimulus(1'b0, 1'b1, 12'sd10);
        checkOutput("reload_edge", signal_o, 22'sd120);
        setCoefs(0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 12'sd10);
        checkOutput("reload_edge+1", signal_o, 22'sd120);
        applyStimulus(1'b0, 1'b0, 12'sd10);
        checkOutput("reload_edge+2", signal_o, 22'sd240);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 12'sd10);
        end
        checkOutput("reload_held", signal_o, 22'sd240);

        // Full-scale negative input and coefficients: the sum wraps modulo 2^22.
        applyStimulus(1'b1, 1'b0, '0);
        setCoefs(-128, -128, -128, -128, -128, -128);
        applyStimulus(1'b0, 1'b1, -12'sd2048);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, -12'sd2048);
            if (i >= 15) checkOutput("wrap_settled", signal_o, -22'sd1048576);
        end

        // Noisy sine with random coefficients, then a single-cycle reset mid-stream.
        setCoefs($urandom_range(1, 127), $urandom_range(1, 127), $urandom_range(1, 127),
                 $urandom_range(1, 127), $urandom_range(1, 127), $urandom_range(1, 127));
        applyStimulus(1'b0, 1'b1, '0);
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0, 1'b0, DW'(sine_tbl[i % 12] + int'($urandom_range(0, 20)) - 10));
        end
        applyStimulus(1'b1, 1'b0, DW'(sine_tbl[6]));
        checkOutput("midreset", signal_o, '0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, DW'(sine_tbl[i % 12] + int'($urandom_range(0, 20)) - 10));
            checkOutput($sformatf("post_reset_%0d", i), signal_o, '0);
        end

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
